// File: rtl/counter_run_arbiter_if.sv
// Bundle of request, run-length and counter-control signals between two
// requesters, the shared up-counter and the counter_run_arbiter.
interface counter_run_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic [WIDTH-1:0] len0;
  logic             req1;
  logic [WIDTH-1:0] len1;
  logic [WIDTH-1:0] count;
  logic             cnt_reset;
  logic             cnt_enable;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             busy;

  // Arbiter side.
  modport slave (
    input  req0, len0, req1, len1, count,
    output cnt_reset, cnt_enable, gnt0, gnt1, done0, done1, busy
  );

  // Requester / counter side.
  modport master (
    output req0, len0, req1, len1, count,
    input  cnt_reset, cnt_enable, gnt0, gnt1, done0, done1, busy
  );
endinterface

// File: rtl/counter_run_arbiter.sv
// Shares one WIDTH-bit up-counter between two requesters. A round-robin winner
// gets the counter cleared for one cycle, then enabled until count reaches the
// length latched at grant, followed by a one-cycle done pulse. Dropping the
// owner's request during CLEAR or RUN aborts the run without a done pulse.
module counter_run_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  counter_run_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] len_q;
  logic             owner;     // 0: requester 0 holds the counter, 1: requester 1
  logic             last_gnt;  // requester granted most recently (aborts included)

  logic owner_req;
  logic run_left;
  logic pick1;

  assign owner_req = owner ? bus.req1 : bus.req0;
  assign run_left  = (bus.count < len_q);

  // Round robin: on contention the requester not granted last wins; a lone
  // request always wins. last_gnt resets to 1 so requester 0 wins first.
  assign pick1 = (bus.req0 && bus.req1) ? ~last_gnt : bus.req1;

  // Counter control is combinational so an abort stops the count in the same
  // cycle the owner's request drops, and the >= compare stops any overshoot.
  assign bus.cnt_reset  = reset | (state == CLEAR);
  assign bus.cnt_enable = (state == RUN) && owner_req && run_left;

  // Arbitration FSM with registered grant, done and busy outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: all state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order in this block.
      state     <= IDLE;
      len_q     <= '0;
      owner     <= 1'b0;
      last_gnt  <= 1'b1;
      bus.gnt0  <= 1'b0;
      bus.gnt1  <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            len_q    <= pick1 ? bus.len1 : bus.len0;
            owner    <= pick1;
            last_gnt <= pick1;
            bus.gnt0 <= ~pick1;
            bus.gnt1 <= pick1;
            bus.busy <= 1'b1;
            state    <= CLEAR;
          end
        end

        CLEAR: begin
          if (!owner_req) begin
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= RUN;
          end
        end

        RUN: begin
          if (!owner_req) begin
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (!run_left) begin
            bus.done0 <= ~owner;
            bus.done1 <= owner;
            state     <= DONE;
          end
        end

        DONE: begin
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          bus.gnt0  <= 1'b0;
          bus.gnt1  <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_run_arbiter.sv
// Self-checking bench for counter_run_arbiter. Includes a behavioural shared
// up-counter driven by the arbiter's cnt_reset/cnt_enable. Completed runs are
// predicted into a scoreboard when requested and matched against done pulses.
module tb_counter_run_arbiter;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  counter_run_arbiter_if #(.WIDTH(WIDTH)) bus ();

  counter_run_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit owner;
    int len;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;

  // Cycle index; stable from just after each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Shared synchronous up-counter with synchronous active-high reset.
  always @(posedge clk) begin
    if (bus.cnt_reset)       bus.count <= '0;
    else if (bus.cnt_enable) bus.count <= WIDTH'(bus.count + 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: grant exclusivity every cycle; each done pulse pops the scoreboard.
  always @(posedge clk) begin
    #3;
    if (mon_en && !reset) begin
      check("gnt_excl", bus.gnt0 & bus.gnt1, 0);
      if (bus.done0 || bus.done1) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("done_both", bus.done0 & bus.done1, 0);
          check("done_owner", bus.done1, mon_e.owner);
          check("done_cycle", cyc, mon_e.done_cyc);
          check("done_count", bus.count, mon_e.len);
          check("done_with_gnt", bus.done1 ? bus.gnt1 : bus.gnt0, 1);
        end
      end
    end
  end

  // One complete run for 'owner' with length n, checked cycle by cycle against
  // the latency formula; 'both' also raises the other request.
  task automatic run_check(input bit owner, input int n, input bit both);
    int t;
    step();
    if (owner) begin bus.req1 = 1'b1; bus.len1 = WIDTH'(n); end
    else       begin bus.req0 = 1'b1; bus.len0 = WIDTH'(n); end
    if (both) begin bus.req0 = 1'b1; bus.req1 = 1'b1; end
    t = cyc;
    sb.push_back('{owner, n, t + n + 3});
    for (int k = 0; k <= n + 4; k++) begin
      if (k > 0) step();
      // Length changes after grant must be ignored.
      if (k == 1) begin
        if (owner) bus.len1 = ~WIDTH'(n);
        else       bus.len0 = ~WIDTH'(n);
      end
      #1;
      check("gnt_owner", owner ? bus.gnt1 : bus.gnt0, (k >= 1 && k <= n + 3));
      check("gnt_other", owner ? bus.gnt0 : bus.gnt1, 0);
      check("busy", bus.busy, (k >= 1 && k <= n + 3));
      check("cnt_reset", bus.cnt_reset, (k == 1));
      check("cnt_enable", bus.cnt_enable, (k >= 2 && k <= n + 1));
      check("done", owner ? bus.done1 : bus.done0, (k == n + 3));
      if (k >= 2) check("count", bus.count, (k - 2 < n) ? (k - 2) : n);
      if (k == n + 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
    end
  endtask

  initial begin : stim
    int t0;
    bit found;

    reset    = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.len0 = '0;
    bus.len1 = '0;

    // Reset held for two cycles.
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      check("rst_cnt_reset", bus.cnt_reset, 1);
      check("rst_gnt", {bus.gnt0, bus.gnt1}, 0);
      check("rst_done", {bus.done0, bus.done1}, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_enable", bus.cnt_enable, 0);
    end
    reset  = 1'b0;
    mon_en = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 5; i++) begin
      #1;
      check("idle_cnt_reset", bus.cnt_reset, 0);
      check("idle_outputs", {bus.cnt_enable, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}, 0);
      step();
    end

    // Contention: both held; req0, req1, req0 served in turn.
    step();
    bus.len0 = 4'd2;
    bus.len1 = 4'd3;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    t0 = cyc;
    sb.push_back('{1'b0, 2, t0 + 5});
    sb.push_back('{1'b1, 3, t0 + 12});
    sb.push_back('{1'b0, 2, t0 + 18});
    for (int i = 0; i < 40 && cyc < t0 + 18; i++) begin
      step();
      if (cyc == t0 + 1)  check("cont_first_gnt0", bus.gnt0, 1);
      if (cyc == t0 + 7)  check("cont_second_gnt1", bus.gnt1, 1);
      if (cyc == t0 + 14) check("cont_third_gnt0", bus.gnt0, 1);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
    step();
    check("cont_sb_empty", sb.size(), 0);

    // Single run, maximum length, zero length.
    run_check(1'b0, 5, 1'b0);
    run_check(1'b0, 15, 1'b0);
    step();
    #1;
    check("max_count_hold", bus.count, 15);
    run_check(1'b1, 0, 1'b0);

    // Abort: drop req0 once count reaches 3.
    step();
    bus.req0 = 1'b1;
    bus.len0 = 4'd8;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.busy && bus.count == 4'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached", found, 1);
    bus.req0 = 1'b0;
    #1;
    check("abort_enable_now", bus.cnt_enable, 0);
    step();
    #1;
    check("abort_gnt", bus.gnt0, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done0, 0);
    for (int i = 0; i < 4; i++) step();
    check("abort_count_hold", bus.count, 3);

    // After an aborted req0 run, contention goes to req1.
    run_check(1'b1, 4, 1'b1);

    // Reset during RUN.
    step();
    bus.req0 = 1'b1;
    bus.len0 = 4'd10;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.busy && bus.count == 4'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("rstrun_reached", found, 1);
    reset = 1'b1;
    #1;
    check("rstrun_cnt_reset_now", bus.cnt_reset, 1);
    step();
    #1;
    check("rstrun_cnt_reset", bus.cnt_reset, 1);
    check("rstrun_outputs", {bus.cnt_enable, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}, 0);
    check("rstrun_count", bus.count, 0);
    reset    = 1'b0;
    bus.req0 = 1'b0;
    step();
    #1;
    check("post_rst_cnt_reset", bus.cnt_reset, 0);
    check("post_rst_busy", bus.busy, 0);
    for (int i = 0; i < 3; i++) step();

    check("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
